// File: rtl/lut_builder.sv
// Builds the 2**SIZE-entry complex LUT sum(+/-coef[j]) in Gray order, one RAM write per cycle.
// Optional build macro LUT_BUILDER_SATURATE_EN: clamp written entries and raise a sticky sat flag.
module lut_builder #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 16,
  parameter int OUT_W = WIDTH + $clog2(SIZE) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SIZE*WIDTH-1:0]   coef_re,
  input  logic [SIZE*WIDTH-1:0]   coef_im,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_en,
  output logic [SIZE-1:0]         wr_addr,
  output logic [OUT_W-1:0]        wr_re,
  output logic [OUT_W-1:0]        wr_im,
  output logic                    sat
);

  localparam int ACC_W  = WIDTH + $clog2(SIZE) + 2;
  localparam int CALC_W = (OUT_W > ACC_W) ? OUT_W : ACC_W;

  typedef enum logic [1:0] {IDLE, INIT, FILL, DONE} state_t;

  state_t state, state_next;
  logic [SIZE*WIDTH-1:0] lat_re, lat_im;
  logic signed [CALC_W-1:0] acc_re, acc_im, acc_re_next, acc_im_next;
  logic [SIZE-1:0] idx, idx_next;
  logic [SIZE:0]   kp1;
  logic [SIZE-1:0] gray_cur, gray_nxt, flip;
  logic [OUT_W-1:0] out_re_next, out_im_next;

  function automatic logic signed [CALC_W-1:0] coef_at(input logic [SIZE*WIDTH-1:0] v, input int j);
    logic signed [WIDTH-1:0] c;
    c = v[j*WIDTH +: WIDTH];
    return CALC_W'(c);
  endfunction

  // Moving from Gray(k) to Gray(k+1) flips exactly one select bit, so each FILL step adds or removes 2*coef[j].
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    acc_re_next = acc_re;
    acc_im_next = acc_im;
    kp1         = {1'b0, idx} + (SIZE+1)'(1);
    gray_cur    = idx ^ (idx >> 1);
    gray_nxt    = kp1[SIZE-1:0] ^ kp1[SIZE:1];
    flip        = gray_cur ^ gray_nxt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = INIT;
          idx_next    = '0;
          acc_re_next = '0;
          acc_im_next = '0;
        end
      end
      INIT: begin
        acc_re_next = acc_re - coef_at(lat_re, int'(idx));
        acc_im_next = acc_im - coef_at(lat_im, int'(idx));
        if (idx == SIZE'(SIZE-1)) begin
          state_next = FILL;
          idx_next   = '0;
        end else begin
          idx_next = idx + SIZE'(1);
        end
      end
      FILL: begin
        if (idx == {SIZE{1'b1}}) begin
          state_next = DONE;
        end else begin
          idx_next = idx + SIZE'(1);
          for (int j = 0; j < SIZE; j++) begin
            if (flip[j]) begin
              if (gray_nxt[j]) begin
                acc_re_next = acc_re + (coef_at(lat_re, j) <<< 1);
                acc_im_next = acc_im + (coef_at(lat_im, j) <<< 1);
              end else begin
                acc_re_next = acc_re - (coef_at(lat_re, j) <<< 1);
                acc_im_next = acc_im - (coef_at(lat_im, j) <<< 1);
              end
            end
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LUT_BUILDER_SATURATE_EN
  localparam logic signed [CALC_W-1:0] OMAX = {{(CALC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CALC_W-1:0] OMIN = ~OMAX;

  logic clip_next;

  always_comb begin
    out_re_next = acc_re_next[OUT_W-1:0];
    out_im_next = acc_im_next[OUT_W-1:0];
    clip_next   = 1'b0;
    if (acc_re_next > OMAX) begin
      out_re_next = OMAX[OUT_W-1:0];
      clip_next   = 1'b1;
    end else if (acc_re_next < OMIN) begin
      out_re_next = OMIN[OUT_W-1:0];
      clip_next   = 1'b1;
    end
    if (acc_im_next > OMAX) begin
      out_im_next = OMAX[OUT_W-1:0];
      clip_next   = 1'b1;
    end else if (acc_im_next < OMIN) begin
      out_im_next = OMIN[OUT_W-1:0];
      clip_next   = 1'b1;
    end
  end

  // sat only reflects entries actually written during the current build.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (state == IDLE && start) begin
      sat <= 1'b0;
    end else if (state_next == FILL && clip_next) begin
      sat <= 1'b1;
    end
  end
`else
  assign out_re_next = acc_re_next[OUT_W-1:0];
  assign out_im_next = acc_im_next[OUT_W-1:0];
  assign sat         = 1'b0;
`endif

  // Outputs are loaded from next-state values so the write data lines up with the registered strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      lat_re  <= '0;
      lat_im  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_re   <= '0;
      wr_im   <= '0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      acc_re <= acc_re_next;
      acc_im <= acc_im_next;
      if (state == IDLE && start) begin
        lat_re <= coef_re;
        lat_im <= coef_im;
      end
      busy  <= (state_next == INIT) || (state_next == FILL);
      done  <= (state_next == DONE);
      wr_en <= (state_next == FILL);
      if (state_next == FILL) begin
        wr_addr <= idx_next ^ (idx_next >> 1);
        wr_re   <= out_re_next;
        wr_im   <= out_im_next;
      end
    end
  end

endmodule

// File: tb/tb_lut_builder.sv
// Self-checking bench for lut_builder: directed steps with random coefficients against a sum-of-signs model.
// Expectations follow LUT_BUILDER_SATURATE_EN when it is defined for the build.
module tb_lut_builder;

  localparam int SZ   = 4;
  localparam int WD   = 8;
  localparam int OW   = 8;
  localparam int NENT = 1 << SZ;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [SZ*WD-1:0] coef_re, coef_im;
  logic busy, done, wr_en, sat;
  logic [SZ-1:0] wr_addr;
  logic signed [OW-1:0] wr_re, wr_im;

  logic start2;
  logic [2*WD-1:0] coef_re2, coef_im2;
  logic busy2, done2, wr_en2, sat2;
  logic [1:0] wr_addr2;
  logic signed [OW-1:0] wr_re2, wr_im2;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int hits[NENT];
  int logRe[NENT];
  int logIm[NENT];
  int order[$];
  int writeCount;

  logic [SZ*WD-1:0] expRe, expIm;

  always #5 clk = ~clk;

  lut_builder #(.SIZE(SZ), .WIDTH(WD), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .coef_re(coef_re), .coef_im(coef_im),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_re(wr_re), .wr_im(wr_im), .sat(sat)
  );

  lut_builder #(.SIZE(2), .WIDTH(WD), .OUT_W(OW)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .coef_re(coef_re2), .coef_im(coef_im2),
    .busy(busy2), .done(done2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_re(wr_re2), .wr_im(wr_im2), .sat(sat2)
  );

  // Record every table write seen on the write port.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      hits[wr_addr]++;
      logRe[wr_addr] = int'(wr_re);
      logIm[wr_addr] = int'(wr_im);
      order.push_back(int'(wr_addr));
      writeCount++;
    end
  end

  function automatic int refSum(input logic [SZ*WD-1:0] c, input int addr);
    int s;
    s = 0;
    for (int j = 0; j < SZ; j++) begin
      logic signed [WD-1:0] v;
      v = c[j*WD +: WD];
      if (((addr >> j) & 1) == 1) s += int'(v);
      else s -= int'(v);
    end
    return s;
  endfunction

  function automatic int refConv(input int s);
`ifdef LUT_BUILDER_SATURATE_EN
    int hi;
    hi = (1 << (OW-1)) - 1;
    if (s > hi) return hi;
    if (s < -hi - 1) return -hi - 1;
    return s;
`else
    logic signed [OW-1:0] b;
    b = OW'(s);
    return int'(b);
`endif
  endfunction

  function automatic int refSat(input logic [SZ*WD-1:0] cr, input logic [SZ*WD-1:0] ci);
    int any;
    any = 0;
`ifdef LUT_BUILDER_SATURATE_EN
    for (int a = 0; a < NENT; a++) begin
      if (refConv(refSum(cr, a)) != refSum(cr, a)) any = 1;
      if (refConv(refSum(ci, a)) != refSum(ci, a)) any = 1;
    end
`endif
    return any;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    writeCount = 0;
    order.delete();
    for (int a = 0; a < NENT; a++) begin
      hits[a]  = 0;
      logRe[a] = 99999;
      logIm[a] = 99999;
    end
  endtask

  // Drive coefficients, pulse start for one cycle; returns in the first busy cycle.
  task automatic applyStimulus(input logic [SZ*WD-1:0] cr, input logic [SZ*WD-1:0] ci);
    coef_re = cr;
    coef_im = ci;
    expRe   = cr;
    expIm   = ci;
    clearLog();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic randomCoefs(output logic [SZ*WD-1:0] cr, output logic [SZ*WD-1:0] ci);
    for (int j = 0; j < SZ; j++) begin
      cr[j*WD +: WD] = WD'($urandom);
      ci[j*WD +: WD] = WD'($urandom);
    end
  endtask

  task automatic waitDone(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int c = 0; c < budget && seen == 0; c++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    if (seen == 0) checkOutput(tag, 0, 1);
  endtask

  task automatic checkTable(input string tag);
    checkOutput({tag, ":writes"}, writeCount, NENT);
    for (int a = 0; a < NENT; a++) begin
      checkOutput($sformatf("%s:hits[%0d]", tag, a), hits[a], 1);
      checkOutput($sformatf("%s:re[%0d]", tag, a), logRe[a], refConv(refSum(expRe, a)));
      checkOutput($sformatf("%s:im[%0d]", tag, a), logIm[a], refConv(refSum(expIm, a)));
    end
    for (int k = 0; k < order.size(); k++)
      checkOutput($sformatf("%s:order[%0d]", tag, k), order[k], k ^ (k >> 1));
    checkOutput({tag, ":sat"}, int'(sat), refSat(expRe, expIm));
  endtask

  initial begin
    logic [SZ*WD-1:0] cr, ci, cr2, ci2;
    int bAddr[4];
    int bRe[4];
    int bIm[4];
    int wc;
    int sawDone;
    int sawWrite;
    int dq[$];
    bit busyHist[0:127];

    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    coef_re = '0;
    coef_im = '0;
    coef_re2 = '0;
    coef_im2 = '0;
    clearLog();
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst:busy", int'(busy), 0);
    checkOutput("rst:done", int'(done), 0);
    checkOutput("rst:wr_en", int'(wr_en), 0);
    checkOutput("rst:wr_addr", int'(wr_addr), 0);
    checkOutput("rst:wr_re", int'(wr_re), 0);
    checkOutput("rst:wr_im", int'(wr_im), 0);
    checkOutput("rst:sat", int'(sat), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic fill on the SIZE=2 instance
    bAddr = '{0, 1, 3, 2};
    bRe   = '{-8, -2, 8, 2};
    bIm   = '{1, 3, -1, -3};
    coef_re2 = {8'sd5, 8'sd3};
    coef_im2 = {-8'sd2, 8'sd1};
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (c >= 3 && c <= 6) begin
        checkOutput($sformatf("basic:wr_en@%0d", c), int'(wr_en2), 1);
        checkOutput($sformatf("basic:addr@%0d", c), int'(wr_addr2), bAddr[c-3]);
        checkOutput($sformatf("basic:re@%0d", c), int'(wr_re2), bRe[c-3]);
        checkOutput($sformatf("basic:im@%0d", c), int'(wr_im2), bIm[c-3]);
      end else begin
        checkOutput($sformatf("basic:wr_en@%0d", c), int'(wr_en2), 0);
      end
      checkOutput($sformatf("basic:done@%0d", c), int'(done2), (c == 7) ? 1 : 0);
      checkOutput($sformatf("basic:busy@%0d", c), int'(busy2), (c <= 6) ? 1 : 0);
    end

    // Full coverage with cycle-exact control timing
    randomCoefs(cr, ci);
    applyStimulus(cr, ci);
    for (int c = 1; c <= SZ + NENT + 2; c++) begin
      if (c > 1) @(negedge clk);
      checkOutput($sformatf("timing:busy@%0d", c), int'(busy), (c <= SZ + NENT) ? 1 : 0);
      checkOutput($sformatf("timing:wr_en@%0d", c), int'(wr_en), (c > SZ && c <= SZ + NENT) ? 1 : 0);
      checkOutput($sformatf("timing:done@%0d", c), int'(done), (c == SZ + NENT + 1) ? 1 : 0);
    end
    checkTable("full");

    // Extra start pulses and coefficient changes during a build
    randomCoefs(cr, ci);
    applyStimulus(cr, ci);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    randomCoefs(cr2, ci2);
    coef_re = cr2;
    coef_im = ci2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignore:done_timeout", 60);
    repeat (6) @(negedge clk);
    checkOutput("ignore:busy_after", int'(busy), 0);
    checkTable("ignore");

    // Reset during FILL on the third write cycle
    randomCoefs(cr, ci);
    applyStimulus(cr, ci);
    wc = 0;
    for (int c = 0; c < 60 && wc < 3; c++) begin
      if (wr_en === 1'b1) wc++;
      if (wc < 3) @(negedge clk);
    end
    checkOutput("rstmid:reached_third_write", wc, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid:wr_en", int'(wr_en), 0);
    checkOutput("rstmid:busy", int'(busy), 0);
    sawDone = 0;
    sawWrite = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1;
      if (wr_en === 1'b1) sawWrite = 1;
    end
    checkOutput("rstmid:no_done", sawDone, 0);
    checkOutput("rstmid:no_write", sawWrite, 0);
    randomCoefs(cr, ci);
    applyStimulus(cr, ci);
    waitDone("rstmid:done_timeout", 60);
    @(negedge clk);
    checkTable("after_rst");

    // Saturation corner: every real coefficient 100
    for (int j = 0; j < SZ; j++) begin
      cr[j*WD +: WD] = 8'd100;
      ci[j*WD +: WD] = 8'd0;
    end
    applyStimulus(cr, ci);
    waitDone("sat:done_timeout", 60);
    @(negedge clk);
`ifdef LUT_BUILDER_SATURATE_EN
    checkOutput("sat:addr0", logRe[0], -128);
    checkOutput("sat:addr15", logRe[NENT-1], 127);
    checkOutput("sat:flag", int'(sat), 1);
`else
    checkOutput("sat:addr0", logRe[0], 112);
    checkOutput("sat:addr15", logRe[NENT-1], -112);
    checkOutput("sat:flag", int'(sat), 0);
`endif
    checkTable("sat");

    // Back-to-back builds with start held high
    randomCoefs(cr, ci);
    coef_re = cr;
    coef_im = ci;
    start = 1'b1;
    for (int c = 0; c < 128 && dq.size() < 2; c++) begin
      @(negedge clk);
      busyHist[c] = busy;
      if (done === 1'b1) begin
        dq.push_back(c);
        if (dq.size() == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("b2b:done_pulses", dq.size(), 2);
    if (dq.size() == 2) begin
      checkOutput("b2b:spacing", dq[1] - dq[0], SZ + NENT + 2);
      checkOutput("b2b:idle_gap", int'(busyHist[dq[0] + 1]), 0);
      checkOutput("b2b:restart", int'(busyHist[dq[0] + 2]), 1);
    end
    repeat (4) @(negedge clk);
    checkOutput("b2b:stopped", int'(busy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
